mem_word_ctrl: RTL

Request sequencer that sits directly upstream of the 4-word bit-slice memory array. It accepts one word read or write per handshake and drives the shared `word_sel`, `rw_mode` and `data` lines of all bit slices. Each select is held long enough for the latch cells to settle, then released. For reads, the controller captures the slices' `OUT` bits and returns them on a response handshake. One instance serves an array of `DATA_W` bit slices in parallel, one slice per data bit.

---
 rtl/mem_word_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_word_ctrl.sv
// mem_word_ctrl: word-level request sequencer for the 4-word bit-slice array.
// Drives shared word_sel/rw_mode/data lines and returns captured slice outputs.
module mem_word_ctrl #(
    parameter int DATA_W = 4,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [3:0]        word_sel,
    output logic              rw_mode,
    output logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] slice_out
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RELEASE,
        RESP
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              wr_q, wr_n;
    logic [1:0]        addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;

    logic              req_ready_n;
    logic              rsp_valid_n;
    logic [DATA_W-1:0] rsp_rdata_n;
    logic [3:0]        word_sel_n;
    logic              rw_mode_n;
    logic [DATA_W-1:0] data_n;

    // Next state, latched request and read capture; outputs are derived
    // from the next state so every output is a plain register.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        wr_n        = wr_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        rsp_rdata_n = rsp_rdata;

        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    wr_n    = req_write;
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    cnt_n   = CNT_LOAD;
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == 4'd0) begin
                    state_n = RELEASE;
                    if (!wr_q) begin
                        rsp_rdata_n = slice_out;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RELEASE: begin
                state_n = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        req_ready_n = 1'b0;
        rsp_valid_n = 1'b0;
        word_sel_n  = 4'b0000;
        rw_mode_n   = 1'b0;
        data_n      = '0;

        unique case (state_n)
            IDLE: begin
                req_ready_n = 1'b1;
            end
            DRIVE: begin
                word_sel_n = 4'b0001 << addr_n;
                rw_mode_n  = wr_n;
                data_n     = wr_n ? wdata_n : '0;
            end
            RELEASE: begin
                // Select drops first; mode and data stay put so the
                // latch cells close on stable inputs.
                rw_mode_n = rw_mode;
                data_n    = data;
            end
            RESP: begin
                rsp_valid_n = 1'b1;
            end
            default: begin
                req_ready_n = 1'b0;
            end
        endcase
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wr_q      <= 1'b0;
            addr_q    <= 2'd0;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            word_sel  <= 4'b0000;
            rw_mode   <= 1'b0;
            data      <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wr_q      <= wr_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            word_sel  <= word_sel_n;
            rw_mode   <= rw_mode_n;
            data      <= data_n;
        end
    end

    // Select is at most one-hot and only live while driving.
    a_word_sel: assert property (@(posedge clk) disable iff (rst)
        $onehot0(word_sel) && (word_sel == 4'b0000 || state == DRIVE));

endmodule
